// File: rtl/mux16_4way_rr_arbiter.sv
// Round-robin 4:1 mux feeding a registered valid/ready output stage with per-requester ack.
// Define ARB_LOCK_EN to add a 'lock' input that keeps priority on the granted requester (bursts).
module mux16_4way_rr_arbiter #(
  parameter int         WIDTH     = 16,
  parameter logic [1:0] RESET_PTR = 2'd0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
`ifdef ARB_LOCK_EN
  input  logic [3:0]       lock,
`endif
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       sel,
  output logic [3:0]       grant,
  output logic [3:0]       ack,
  output logic             busy
);

  typedef enum logic {ST_IDLE, ST_XFER} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_out;
  logic             r_valid;
  logic [1:0]       r_sel;
  logic [1:0]       r_ptr;

  logic [1:0]       w_pick;
  logic [WIDTH-1:0] w_data;
  logic [1:0]       w_next_ptr;

  // Walk from the lowest-priority offset down so the first hit after r_ptr wins.
  always_comb begin
    w_pick = r_ptr;
    for (int i = 3; i >= 0; i--) begin
      if (req[r_ptr + 2'(i)]) begin
        w_pick = r_ptr + 2'(i);
      end
    end
  end

  always_comb begin
    w_data = a;
    case (w_pick)
      2'd0:    w_data = a;
      2'd1:    w_data = b;
      2'd2:    w_data = c;
      default: w_data = d;
    endcase
  end

`ifdef ARB_LOCK_EN
  assign w_next_ptr = (lock[r_sel] && req[r_sel]) ? r_sel : r_sel + 2'd1;
`else
  assign w_next_ptr = r_sel + 2'd1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_out   <= '0;
      r_valid <= 1'b0;
      r_sel   <= 2'd0;
      r_ptr   <= RESET_PTR;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_sel   <= w_pick;
            r_out   <= w_data;
            r_valid <= 1'b1;
            r_state <= ST_XFER;
          end
        end
        ST_XFER: begin
          // Data stays captured until the consumer takes it; out is not cleared afterwards.
          if (out_ready) begin
            r_valid <= 1'b0;
            r_ptr   <= w_next_ptr;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out       = r_out;
  assign out_valid = r_valid;
  assign sel       = r_sel;
  assign grant     = r_valid ? (4'b0001 << r_sel) : 4'b0000;
  assign ack       = grant & {4{out_ready}};
  assign busy      = (r_state == ST_XFER);

endmodule
